// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the BIP serial link UART blocks (receiver and
// transmitter).
//   state_t    : frame FSM state encoding, common to both directions.
//   OVERSAMPLE : baud ticks per bit period.
//   MID_TICK   : tick index that lands in the middle of the start bit.
//   cnt_width  : helper returning a counter width for a given number of states.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    // Bits needed to count 0 .. n-1; never less than 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Multi-stage single-bit synchroniser for an asynchronous input.
// Parameters:
//   NB_SYNC : number of flip-flop stages (2 or more).
//   RST_VAL : value loaded into every stage on reset.
// Ports:
//   clk : destination clock.
//   rst : synchronous active-high reset.
//   d   : asynchronous input.
//   q   : synchronised output, NB_SYNC cycles behind d.
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int   NB_SYNC = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [NB_SYNC-1:0] stages;

    // NOTE: registers are written with non-blocking assignments so every
    // stage samples the value its predecessor held before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= {NB_SYNC{RST_VAL}};
        end else begin
            stages <= {stages[NB_SYNC-2:0], d};
        end
    end

    assign q = stages[NB_SYNC-1];

endmodule

// File: rtl/rx_uart.sv
// -----------------------------------------------------------------------------
// rx_uart
// UART receiver for the BIP serial link. Oversamples the line at 16 ticks per
// bit, deserialises one frame (NB_DATA data bits, LSB first, no parity) and
// reports the result with single-cycle registered strobes.
// Parameters:
//   NB_DATA : data bits per frame.
//   SB_TICK : ticks spent in the stop bit (16, 24 or 32).
//   NB_SYNC : synchroniser stages on i_rx.
// Ports:
//   i_clk       : system clock, posedge.
//   i_rst       : synchronous active-high reset.
//   i_tick      : baud tick, 16 per bit, one clock wide.
//   i_rx        : asynchronous serial input, idles high.
//   o_data      : last correctly framed byte, held until the next good frame.
//   o_rx_done   : one-cycle pulse, o_data updated this cycle.
//   o_frame_err : one-cycle pulse, stop bit sampled low, frame discarded.
// -----------------------------------------------------------------------------
module rx_uart
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int NB_SYNC = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    // The tick counter is 4 bits for one stop bit; it widens only when a
    // longer stop period (24 or 32 ticks) needs the extra range.
    localparam int S_W = (SB_TICK > OVERSAMPLE) ? cnt_width(SB_TICK) : cnt_width(OVERSAMPLE);
    localparam int N_W = cnt_width(NB_DATA);

    localparam logic [S_W-1:0] S_MID  = S_W'(MID_TICK);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [S_W-1:0] S_ONE  = S_W'(1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);
    localparam logic [N_W-1:0] N_ONE  = N_W'(1);

    logic rx_s;

    state_t             state_q, state_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic               done_d, err_d;

    sync_2ff #(
        .NB_SYNC (NB_SYNC),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (i_clk),
        .rst (i_rst),
        .d   (i_rx),
        .q   (rx_s)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            // Start detect is level-sensitive and does not wait for a tick;
            // a tick arriving in this same cycle is deliberately not counted.
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end

            START: begin
                if (i_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[NB_DATA-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end

            STOP: begin
                if (i_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        s_d     = '0;
                        done_d  = rx_s;
                        err_d   = !rx_s;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the shift register and output byte are plain flops, not a memory,
    // so they are reset like the rest of the state and never expose stale bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            o_rx_done   <= done_d;
            o_frame_err <= err_d;
            if (done_d) begin
                o_data <= b_q;
            end
        end
    end

endmodule

// File: tb/tb_rx_uart.sv
// -----------------------------------------------------------------------------
// tb_rx_uart
// Self-checking bench for rx_uart: a table of whole frames with expected
// strobes and byte, followed by hand-written sequences for glitches,
// back-to-back frames, mid-frame reset and a gapped, skewed tick stream.
// -----------------------------------------------------------------------------
module tb_rx_uart;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;

    rx_uart #(
        .NB_DATA (8),
        .SB_TICK (16),
        .NB_SYNC (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tick      (tick),
        .i_rx        (rx),
        .o_data      (data),
        .o_rx_done   (rx_done),
        .o_frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick generator: one tick every 4 clocks, or every 3..7 clocks in gap mode.
    bit gap_mode = 1'b0;
    initial begin
        tick = 1'b0;
        forever begin
            int p;
            p = gap_mode ? int'($urandom_range(3, 7)) : 4;
            repeat (p - 1) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    // Monitor: counts strobes, remembers the bytes and tick stamps of the
    // last two done pulses, and flags overlapping or stretched strobes.
    int         tick_cnt  = 0;
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         viol_cnt  = 0;
    int         t_last    = 0;
    int         t_prev    = 0;
    logic [7:0] byte_last = '0;
    logic [7:0] byte_prev = '0;
    logic       done_q    = 1'b0;
    logic       err_q     = 1'b0;

    always @(posedge clk) begin
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    always @(negedge clk) begin
        done_q <= rx_done;
        err_q  <= frame_err;
        if (rx_done) begin
            done_cnt  <= done_cnt + 1;
            t_prev    <= t_last;
            t_last    <= tick_cnt;
            byte_prev <= byte_last;
            byte_last <= data;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if ((rx_done && frame_err) || (rx_done && done_q) || (frame_err && err_q))
            viol_cnt <= viol_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for k baud ticks; returns just after the posedge that sampled the k-th.
    task automatic wait_ticks(input int k);
        repeat (k) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
    endtask

    task automatic drive_rx(input logic v, input bit skew);
        if (skew) #($urandom_range(1, 9));
        else      #1;
        rx = v;
    endtask

    // One 8N1 frame. A low stop bit is held only past its sample point and
    // then released, so the receiver's restart after the error sees a glitch
    // and produces no second pulse.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit skew);
        drive_rx(1'b0, skew);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            drive_rx(d[i], skew);
            wait_ticks(16);
        end
        if (stop) begin
            drive_rx(1'b1, skew);
            wait_ticks(16);
        end else begin
            drive_rx(1'b0, skew);
            wait_ticks(10);
            drive_rx(1'b1, skew);
            wait_ticks(6);
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic       stop;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0;
        logic [7:0] held;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h12, 1'b1, 1, 0, 8'h12};
        vecs[3] = '{8'h6B, 1'b0, 0, 1, 8'h12};
        vecs[4] = '{8'hFE, 1'b1, 1, 0, 8'hFE};
        vecs[5] = '{8'h01, 1'b1, 1, 0, 8'h01};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset o_data", data, 8'h00);
        check("reset o_rx_done", rx_done, 1'b0);
        check("reset o_frame_err", frame_err, 1'b0);
        wait_ticks(4);

        // Table of whole frames separated by a short idle gap.
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].din, vecs[i].stop, 1'b0);
            wait_ticks(4);
            check($sformatf("vec%0d done count", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("vec%0d err count", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d o_data", i), data, vecs[i].exp_data);
        end

        // Start-bit glitch: low for 4 ticks only, must be dropped silently.
        d0   = done_cnt;
        e0   = err_cnt;
        held = data;
        drive_rx(1'b0, 1'b0);
        wait_ticks(4);
        drive_rx(1'b1, 1'b0);
        wait_ticks(24);
        check("glitch done count", done_cnt - d0, 0);
        check("glitch err count", err_cnt - e0, 0);
        check("glitch o_data held", data, held);

        // Back-to-back frames with no idle gap.
        d0 = done_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_ticks(4);
        check("b2b done count", done_cnt - d0, 2);
        check("b2b first byte", byte_prev, 8'h00);
        check("b2b second byte", byte_last, 8'hFF);
        check("b2b spacing in range",
              ((t_last - t_prev) >= 159 && (t_last - t_prev) <= 161), 1'b1);
        check("b2b o_data", data, 8'hFF);

        // Reset in the middle of data bit 4 of 0x55, then the line goes idle.
        d0 = done_cnt;
        e0 = err_cnt;
        drive_rx(1'b0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            drive_rx(logic'((8'h55 >> i) & 8'h01), 1'b0);
            wait_ticks(16);
        end
        drive_rx(1'b1, 1'b0);
        wait_ticks(8);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rx = 1'b1;
        wait_ticks(80);
        check("midreset done count", done_cnt - d0, 0);
        check("midreset err count", err_cnt - e0, 0);
        check("midreset o_data", data, 8'h00);

        d0 = done_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(4);
        check("post-reset done count", done_cnt - d0, 1);
        check("post-reset o_data", data, 8'h81);

        // Gapped ticks and asynchronously skewed line edges.
        gap_mode = 1'b1;
        wait_ticks(4);
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_ticks(4);
        check("gapped done count", done_cnt - d0, 1);
        check("gapped err count", err_cnt - e0, 0);
        check("gapped o_data", data, 8'h5A);

        check("strobe overlap or stretch", viol_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
